// File: rtl/bin2bcd_seq_pkg.sv
// Package bin2bcd_pkg: shared types and helpers for the sequential
// binary-to-BCD converter (bin2bcd_seq).
//   bcd_digit_t    one packed BCD digit
//   ADD3_THRESH    digit value at and above which double dabble adds 3
//   state_t        converter FSM states
//   is_zero_digit  1 when a digit holds 0 (used for leading-zero blanking)
package bin2bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t ADD3_THRESH = 4'd5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic logic is_zero_digit(input bcd_digit_t d);
    return (d == 4'd0);
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Interface bin2bcd_seq_if: start/busy/done handshake plus data for bin2bcd_seq.
//   start      request (master -> slave)
//   bin_in     unsigned binary value, WIDTH bits (master -> slave)
//   busy       conversion in progress (slave -> master)
//   done       1-cycle pulse, results just updated (slave -> master)
//   bcd_out    4*DIGITS packed BCD digits, digit 0 = units (slave -> master)
//   overflow   last value did not fit in DIGITS digits (slave -> master)
//   blank_mask leading-zero flags, only when BIN2BCD_BLANK_EN is defined
interface bin2bcd_seq_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
);

  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0]     blank_mask;
`endif

  modport master (
    output start, bin_in,
`ifdef BIN2BCD_BLANK_EN
    input  blank_mask,
`endif
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
`ifdef BIN2BCD_BLANK_EN
    output blank_mask,
`endif
    output busy, done, bcd_out, overflow
  );

endinterface

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Module bcd_add3: combinational double-dabble digit correction.
//   din   BCD digit before the shift
//   dout  din + 3 when din >= 5, else din
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  always_comb begin
    dout = (din >= ADD3_THRESH) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Module bin2bcd_seq: sequential binary-to-BCD converter, shift-and-add-3,
// one input bit per clock.  WIDTH clocks from the accepting edge to done;
// a start seen in DONE is accepted immediately (WIDTH+1 clocks per result).
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  bin2bcd_seq_if slave: start, bin_in, busy, done, bcd_out, overflow
//        and, with BIN2BCD_BLANK_EN defined, blank_mask (leading-zero flags)
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic            clk,
  input  logic            rst,
  bin2bcd_seq_if.slave    bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned BW    = 4 * DIGITS;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   shreg;
  logic [BW-1:0]      scratch;
  logic               ovf_s;
  logic [BW-1:0]      bcd_q;
  logic               ovf_q;

  logic [BW-1:0]      adj;
  logic [BW-1:0]      scratch_sh;
  logic               ovf_sh;
  logic               last;
  logic               accept;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // Corrected digits shift left by one, taking the next binary MSB as the
  // new units LSB; the top digit's MSB falls off into the sticky overflow.
  assign scratch_sh = {adj[BW-2:0], shreg[WIDTH-1]};
  assign ovf_sh     = ovf_s | adj[BW-1];
  assign last       = (cnt == CNT_W'(WIDTH - 1));
  assign accept     = bus.start && (state != SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BIN2BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_nxt;
  logic              all_zero;

  // Walk from the top digit down: a digit blanks only while every digit
  // above it (and itself) is zero.  Units are never blanked.
  always_comb begin
    blank_nxt = '0;
    all_zero  = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      all_zero = all_zero & is_zero_digit(scratch_sh[4*(DIGITS-1-i) +: 4]);
      if (DIGITS - 1 - i != 0) blank_nxt[DIGITS-1-i] = all_zero;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_q <= BLANK_RST;
    end else if (state == SHIFT && last) begin
      blank_q <= blank_nxt;
    end
  end

  assign bus.blank_mask = blank_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      shreg   <= '0;
      scratch <= '0;
      ovf_s   <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      shreg   <= bus.bin_in;
      scratch <= '0;
      ovf_s   <= 1'b0;
    end else if (state == SHIFT) begin
      cnt     <= cnt + CNT_W'(1);
      shreg   <= shreg << 1;
      scratch <= scratch_sh;
      ovf_s   <= ovf_sh;
      if (last) begin
        bcd_q <= scratch_sh;
        ovf_q <= ovf_sh;
      end
    end
  end

  assign bus.busy     = (state == SHIFT);
  assign bus.done     = (state == DONE);
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: two instances (16b/5 digits and
// 16b/4 digits) driven in lockstep from one start/bin_in pair.
// Blank-mask checks are compiled only with BIN2BCD_BLANK_EN defined.
module tb_bin2bcd_seq;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bin   = '0;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  bin2bcd_seq_if #(.WIDTH(16), .DIGITS(5)) b5 ();
  bin2bcd_seq_if #(.WIDTH(16), .DIGITS(4)) b4 ();

  assign b5.start  = start;
  assign b5.bin_in = bin;
  assign b4.start  = start;
  assign b4.bin_in = bin;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u5 (.clk(clk), .rst(rst), .bus(b5.slave));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts one conversion and waits for done; lat = clocks after the accepting edge.
  task automatic convert(input logic [15:0] v, output int lat);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", 32'(b5.busy), 32'd1);
    lat = 0;
    while (!b5.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) check("done_timeout", 32'(lat), 32'd16);
    check("done4_with_done5", 32'(b4.done), 32'd1);
    check("busy_low_at_done", 32'(b5.busy), 32'd0);
  endtask

  typedef struct {
    logic [15:0] bin;
    logic [19:0] e5;
    logic [15:0] e4;
    logic        o4;
    logic [4:0]  m5;
    logic [3:0]  m4;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    int ndone;
    int first;
    int cnt;

    vecs[0] = '{16'd65535, 20'h65535, 16'h5535, 1'b1, 5'b00000, 4'b0000};
    vecs[1] = '{16'd0,     20'h00000, 16'h0000, 1'b0, 5'b11110, 4'b1110};
    vecs[2] = '{16'd12345, 20'h12345, 16'h2345, 1'b1, 5'b00000, 4'b0000};
    vecs[3] = '{16'd9999,  20'h09999, 16'h9999, 1'b0, 5'b10000, 4'b0000};
    vecs[4] = '{16'd10000, 20'h10000, 16'h0000, 1'b1, 5'b00000, 4'b1110};
    vecs[5] = '{16'd305,   20'h00305, 16'h0305, 1'b0, 5'b11000, 4'b1000};
    vecs[6] = '{16'd1,     20'h00001, 16'h0001, 1'b0, 5'b11110, 4'b1110};
    vecs[7] = '{16'd4096,  20'h04096, 16'h4096, 1'b0, 5'b10000, 4'b0000};

    // Reset state
    #1;
    check("rst_busy", 32'(b5.busy), 32'd0);
    check("rst_done", 32'(b5.done), 32'd0);
    check("rst_bcd5", 32'(b5.bcd_out), 32'h0);
    check("rst_ovf4", 32'(b4.overflow), 32'd0);
`ifdef BIN2BCD_BLANK_EN
    check("rst_blank5", 32'(b5.blank_mask), 32'h1e);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table of directed vectors
    for (int i = 0; i < 8; i++) begin
      convert(vecs[i].bin, lat);
      check($sformatf("latency[%0d]", i), 32'(lat), 32'd16);
      check($sformatf("bcd5[%0d]", i), 32'(b5.bcd_out), 32'(vecs[i].e5));
      check($sformatf("ovf5[%0d]", i), 32'(b5.overflow), 32'd0);
      check($sformatf("bcd4[%0d]", i), 32'(b4.bcd_out), 32'(vecs[i].e4));
      check($sformatf("ovf4[%0d]", i), 32'(b4.overflow), 32'(vecs[i].o4));
`ifdef BIN2BCD_BLANK_EN
      check($sformatf("blank5[%0d]", i), 32'(b5.blank_mask), 32'(vecs[i].m5));
      check($sformatf("blank4[%0d]", i), 32'(b4.blank_mask), 32'(vecs[i].m4));
`endif
      @(negedge clk);
      check($sformatf("done_pulse_end[%0d]", i), 32'(b5.done), 32'd0);
    end

    // start/bin_in changes while busy are ignored; outputs hold during SHIFT
    @(negedge clk);
    start = 1'b1;
    bin   = 16'd1234;
    ndone = 0;
    first = -1;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      if (c == 4) begin
        start = 1'b1;
        bin   = 16'd9999;
      end else begin
        start = 1'b0;
        if (c == 0) bin = 16'd5555;
      end
      if (c == 3) check("hold_during_shift", 32'(b5.bcd_out), 32'h04096);
      if (b5.done) begin
        ndone++;
        if (first < 0) first = c;
      end
    end
    check("ignored_start_done_count", 32'(ndone), 32'd1);
    check("ignored_start_latency", 32'(first), 32'd16);
    check("ignored_start_bcd5", 32'(b5.bcd_out), 32'h01234);

    // Async reset mid-conversion aborts it
    @(negedge clk);
    start = 1'b1;
    bin   = 16'd4321;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(b5.busy), 32'd0);
    check("abort_done", 32'(b5.done), 32'd0);
    check("abort_bcd5", 32'(b5.bcd_out), 32'h0);
`ifdef BIN2BCD_BLANK_EN
    check("abort_blank5", 32'(b5.blank_mask), 32'h1e);
`endif
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b5.done || b5.busy) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    convert(16'd9999, lat);
    check("after_abort_latency", 32'(lat), 32'd16);
    check("after_abort_bcd5", 32'(b5.bcd_out), 32'h09999);

    // start held high: back-to-back conversions every WIDTH+1 clocks
    @(negedge clk);
    start = 1'b1;
    bin   = 16'd42;
    cnt   = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!b5.done && cnt < 40);
    check("b2b_first_period", 32'(cnt), 32'd17);
    check("b2b_first_bcd5", 32'(b5.bcd_out), 32'h00042);
    bin = 16'd43;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!b5.done && cnt < 40);
    check("b2b_second_period", 32'(cnt), 32'd17);
    check("b2b_second_bcd5", 32'(b5.bcd_out), 32'h00043);
    start = 1'b0;
    @(negedge clk);
    check("b2b_idle_after", 32'(b5.done | b5.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
